seg7_scan_mux: RTL

Parametrised, time-multiplexed driver for a DIGITS-wide common-anode 7-segment display in the stopwatch/timer datapath. It accepts a packed BCD (optionally hex) value with a load strobe and scans one digit at a time. Per-digit dead time suppresses ghosting, optional leading-zero blanking is supported, and value updates are tear-free at frame boundaries. It sits between the counter/timekeeping logic and the board pins.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_decode.sv | 38 +++
 rtl/seg7_scan_mux.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seg7 display driver: active-low segment
// patterns ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Decimal digits
    localparam seg_t SEG_0 = 7'b1000000;
    localparam seg_t SEG_1 = 7'b1111001;
    localparam seg_t SEG_2 = 7'b0100100;
    localparam seg_t SEG_3 = 7'b0110000;
    localparam seg_t SEG_4 = 7'b0011001;
    localparam seg_t SEG_5 = 7'b0010010;
    localparam seg_t SEG_6 = 7'b0000010;
    localparam seg_t SEG_7 = 7'b1111000;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0010000;

    // Hex letters
    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b0000011;
    localparam seg_t SEG_C = 7'b1000110;
    localparam seg_t SEG_D = 7'b0100001;
    localparam seg_t SEG_E = 7'b0000110;
    localparam seg_t SEG_F = 7'b0001110;

    // Special patterns
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_OFF   = 7'b1111111;
    localparam seg_t SEG_BLANK = SEG_OFF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-low 7-segment pattern.
// Define SEG7_HEX_EN to show A..F for codes 10..15; otherwise they show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    // Table lookup; non-decimal codes depend on the hex build option.
    always_comb begin
        // NOTE: assign a default before the case so no code path infers a latch.
        seg_o = SEG_DASH;
        case (code_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
`ifdef SEG7_HEX_EN
            4'd10:   seg_o = SEG_A;
            4'd11:   seg_o = SEG_B;
            4'd12:   seg_o = SEG_C;
            4'd13:   seg_o = SEG_D;
            4'd14:   seg_o = SEG_E;
            4'd15:   seg_o = SEG_F;
`else
            default: seg_o = SEG_DASH;
`endif
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver. Scans one digit per
// SCAN_DIV-cycle slot with DEAD_CYC cycles of anode-off dead time, supports
// leading-zero blanking and swaps in newly loaded values only at frame
// boundaries. Define SEG7_HEX_EN (seen by seg7_decode) for hex letters.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                load,
    input  logic                blank_lz,
    output logic [6:0]          leds,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                frame
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VAL_W = 4 * DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(DEAD_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Scan position
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Displayed (shadow) and waiting (pending) data
    logic [VAL_W-1:0]  shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [VAL_W-1:0]  pend_val_q, pend_val_d;
    logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic              pend_flag_q, pend_flag_d;

    // Registered outputs
    logic [6:0]        leds_q, leds_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              frame_q, frame_d;

    // Internal combinational signals
    logic              slot_end;
    logic              frame_wrap;
    logic [3:0]        cur_code;
    logic              cur_dp;
    logic [DIGITS-1:0] lz_mask;
    logic              cur_blank;
    logic [6:0]        dec_seg;

    // Prescaler and digit index advance; the index wrap marks the frame boundary.
    always_comb begin
        slot_end   = (cnt_q == CNT_LAST);
        frame_wrap = slot_end && (idx_q == IDX_LAST);
        cnt_d      = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Load capture: loads park in pending, which is promoted at the frame
    // boundary; a load landing on the boundary itself goes straight to shadow.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_flag_d  = pend_flag_q;
        if (frame_wrap) begin
            if (load) begin
                shadow_val_d = value;
                shadow_dp_d  = dp_in;
            end else if (pend_flag_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
            end
            pend_flag_d = 1'b0;
        end else if (load) begin
            pend_val_d  = value;
            pend_dp_d   = dp_in;
            pend_flag_d = 1'b1;
        end
    end

    // Digit select and leading-zero mask: lz_mask[k] is set when shadow
    // digits k..DIGITS-1 are all zero.
    always_comb begin
        logic run_zero;
        cur_code = 4'd0;
        cur_dp   = 1'b0;
        run_zero = 1'b1;
        lz_mask  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run_zero   = run_zero && (shadow_val_q[4*k +: 4] == 4'd0);
            lz_mask[k] = run_zero;
        end
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_code  = shadow_val_q[4*k +: 4];
                cur_dp    = shadow_dp_q[k];
                cur_blank = blank_lz && (k > 0) && lz_mask[k];
            end
        end
    end

    seg7_decode u_decode (
        .code_i (cur_code),
        .seg_o  (dec_seg)
    );

    // Output next-state: anode on only after the dead time, active-low drive.
    always_comb begin
        leds_d  = cur_blank ? SEG_BLANK : dec_seg;
        dp_d    = ~cur_dp;
        frame_d = frame_wrap;
        an_d    = '1;
        for (int k = 0; k < DIGITS; k++) begin
            an_d[k] = !((cnt_q >= CNT_ON) && (idx_q == IDX_W'(k)));
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            // NOTE: shadow/pending are ordinary flops, not a RAM, so they are
            // reset; this discards pending data and fixes the first frame.
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
            leds_q       <= SEG_OFF;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_flag_q  <= pend_flag_d;
            leds_q       <= leds_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
        end
    end

    assign leds  = leds_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule
